dict_update_ctrl: RTL and testbench

- Sequences dictionary updates for the word decompressor into the dual-bank FIFO dictionary (bank 1 = wr/w_data, bank 2 = wr2/w_data2).
- Accepts up to two decoded words per cycle and buffers them in a small staging queue.
- Steers each word to the correct bank so the dictionary's interleaved order (bank1[0], bank2[0], bank1[1], ...) always matches arrival order.
- Holds writes while the decoder needs a stable dictionary snapshot (i_hold); frames each compressed block with a start/done handshake.

---
 rtl/dict_ctrl_pkg.sv | 14 +
 rtl/stage_fifo2.sv | 52 +++++
 rtl/dict_update_ctrl.sv | 130 +++++++++++++
 tb/tb_dict_update_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dict_ctrl_pkg.sv
// Shared types and constants for the dictionary update controller.
package dict_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ctrl_state_e;

  localparam logic BANK1 = 1'b0;
  localparam logic BANK2 = 1'b1;

endpackage

// File: rtl/stage_fifo2.sv
// Small staging queue: 0-2 pushes and 0-2 pops per cycle, exposes head, head+1 and count.
module stage_fifo2 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_push_n,
  input  logic [DATA_WIDTH-1:0] i_push_d0,
  input  logic [DATA_WIDTH-1:0] i_push_d1,
  input  logic [1:0]            i_pop_n,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [DATA_WIDTH-1:0] o_head1,
  output logic [CW-1:0]         o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd;
  logic [AW-1:0]         r_wr;
  logic [CW-1:0]         r_count;
  logic [AW-1:0]         w_rd1;
  logic [AW-1:0]         w_wr1;

  // DEPTH is a power of two, so plain AW-bit arithmetic wraps the pointers.
  assign w_rd1 = r_rd + AW'(1);
  assign w_wr1 = r_wr + AW'(1);

  always_ff @(posedge i_clk) begin
    if (i_push_n != 2'd0) r_mem[r_wr]  <= i_push_d0;
    if (i_push_n == 2'd2) r_mem[w_wr1] <= i_push_d1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= r_rd + AW'(i_pop_n);
      r_wr    <= r_wr + AW'(i_push_n);
      r_count <= r_count + CW'(i_push_n) - CW'(i_pop_n);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_head1 = r_mem[w_rd1];
  assign o_count = r_count;

endmodule

// File: rtl/dict_update_ctrl.sv
// Stages decoded words and steers them into the dual-bank dictionary in arrival order.
module dict_update_ctrl
  import dict_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STAGE_DEPTH = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_hold,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_push,
  input  logic [DATA_WIDTH-1:0] in_word0,
  input  logic [DATA_WIDTH-1:0] in_word1,
  input  logic                  in_last,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  wr2,
  output logic [DATA_WIDTH-1:0] w_data2,
  output logic                  o_busy,
  output logic                  o_blk_done,
  output logic [CNT_WIDTH-1:0]  o_push_cnt
);

  localparam int unsigned CW = $clog2(STAGE_DEPTH) + 1;

  ctrl_state_e           r_state;
  logic                  r_bank_sel;
  logic [CNT_WIDTH-1:0]  r_push_cnt;

  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_free;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_head1;
  logic                  w_accept;
  logic [1:0]            w_push_n;
  logic [DATA_WIDTH-1:0] w_push_d0;
  logic [1:0]            w_pop_n;
  logic [CNT_WIDTH:0]    w_cnt_sum;

  assign w_free   = CW'(STAGE_DEPTH) - w_count;
  assign in_ready = (r_state == RUN) && (w_free >= CW'(2));
  assign w_accept = in_valid && in_ready;

  // A lone word1 (push=10) is compacted into the first push slot.
  assign w_push_n  = w_accept ? ({1'b0, in_push[0]} + {1'b0, in_push[1]}) : 2'd0;
  assign w_push_d0 = in_push[0] ? in_word0 : in_word1;

  always_comb begin
    w_pop_n = 2'd0;
    if (!i_hold) begin
      if (w_count >= CW'(2))      w_pop_n = 2'd2;
      else if (w_count == CW'(1)) w_pop_n = 2'd1;
    end
  end

  stage_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (STAGE_DEPTH),
    .CW         (CW)
  ) u_stage (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_push_n  (w_push_n),
    .i_push_d0 (w_push_d0),
    .i_push_d1 (in_word1),
    .i_pop_n   (w_pop_n),
    .o_head    (w_head),
    .o_head1   (w_head1),
    .o_count   (w_count)
  );

  always_comb begin
    wr      = 1'b0;
    wr2     = 1'b0;
    w_data  = '0;
    w_data2 = '0;
    if (w_pop_n == 2'd2) begin
      wr  = 1'b1;
      wr2 = 1'b1;
      if (r_bank_sel == BANK1) begin
        w_data  = w_head;
        w_data2 = w_head1;
      end else begin
        w_data2 = w_head;
        w_data  = w_head1;
      end
    end else if (w_pop_n == 2'd1) begin
      if (r_bank_sel == BANK1) begin
        wr     = 1'b1;
        w_data = w_head;
      end else begin
        wr2     = 1'b1;
        w_data2 = w_head;
      end
    end
  end

  assign w_cnt_sum = {1'b0, r_push_cnt} + (CNT_WIDTH + 1)'(wr) + (CNT_WIDTH + 1)'(wr2);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_bank_sel <= BANK1;
      r_push_cnt <= '0;
    end else begin
      if (w_pop_n == 2'd1) r_bank_sel <= ~r_bank_sel;

      if (r_state == IDLE && i_start) r_push_cnt <= '0;
      else if (w_cnt_sum[CNT_WIDTH])  r_push_cnt <= '1;
      else                            r_push_cnt <= w_cnt_sum[CNT_WIDTH-1:0];

      case (r_state)
        IDLE:    if (i_start) r_state <= RUN;
        RUN:     if (w_accept && in_last) r_state <= DRAIN;
        DRAIN:   if (w_count == '0) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state != IDLE);
  assign o_blk_done = (r_state == DONE);
  assign o_push_cnt = r_push_cnt;

endmodule

// File: tb/tb_dict_update_ctrl.sv
// Directed bench for dict_update_ctrl: bank steering, hold, block framing and reset.
module tb_dict_update_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_hold = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_push = 2'b00;
  logic [31:0] in_word0 = '0;
  logic [31:0] in_word1 = '0;
  logic        in_last = 1'b0;
  logic        wr, wr2;
  logic [31:0] w_data, w_data2;
  logic        o_busy, o_blk_done;
  logic [15:0] o_push_cnt;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 i_clk = ~i_clk;

  dict_update_ctrl #(
    .DATA_WIDTH  (32),
    .STAGE_DEPTH (4),
    .CNT_WIDTH   (16)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_hold     (i_hold),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_push    (in_push),
    .in_word0   (in_word0),
    .in_word1   (in_word1),
    .in_last    (in_last),
    .wr         (wr),
    .w_data     (w_data),
    .wr2        (wr2),
    .w_data2    (w_data2),
    .o_busy     (o_busy),
    .o_blk_done (o_blk_done),
    .o_push_cnt (o_push_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] p, input logic [31:0] w0,
                       input logic [31:0] w1, input logic last);
    in_valid = v;
    in_push  = p;
    in_word0 = w0;
    in_word1 = w1;
    in_last  = last;
  endtask

  task automatic idle_in();
    drive(1'b0, 2'b00, '0, '0, 1'b0);
  endtask

  initial begin
    // reset state
    #2;
    check_eq("rst_wr", {31'd0, wr}, 32'd0);
    check_eq("rst_wr2", {31'd0, wr2}, 32'd0);
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_done", {31'd0, o_blk_done}, 32'd0);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_cnt", {16'd0, o_push_cnt}, 32'd0);
    tick();
    i_reset = 1'b1;
    tick();

    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    settle();
    check_eq("start_busy", {31'd0, o_busy}, 32'd1);
    check_eq("start_ready", {31'd0, in_ready}, 32'd1);

    // pair into empty queue at bank_sel=0
    drive(1'b1, 2'b11, 32'hA0000001, 32'hA0000002, 1'b0);
    tick();
    idle_in();
    settle();
    check_eq("A_wr", {31'd0, wr}, 32'd1);
    check_eq("A_wdata", w_data, 32'hA0000001);
    check_eq("A_wr2", {31'd0, wr2}, 32'd1);
    check_eq("A_wdata2", w_data2, 32'hA0000002);
    tick();
    settle();
    check_eq("A_cnt", {16'd0, o_push_cnt}, 32'd2);
    check_eq("A_idle_wr", {31'd0, wr | wr2}, 32'd0);

    // three single pushes alternate banks
    drive(1'b1, 2'b01, 32'hB0000001, '0, 1'b0);
    tick();
    drive(1'b1, 2'b01, 32'hB0000002, '0, 1'b0);
    settle();
    check_eq("B1_wr", {30'd0, wr, wr2}, 32'd2);
    check_eq("B1_data", w_data, 32'hB0000001);
    tick();
    drive(1'b1, 2'b01, 32'hB0000003, '0, 1'b0);
    settle();
    check_eq("B2_wr", {30'd0, wr, wr2}, 32'd1);
    check_eq("B2_data", w_data2, 32'hB0000002);
    tick();
    idle_in();
    settle();
    check_eq("B3_wr", {30'd0, wr, wr2}, 32'd2);
    check_eq("B3_data", w_data, 32'hB0000003);
    tick();

    // pair from bank_sel=1; i_start here must be ignored
    drive(1'b1, 2'b11, 32'hC0000001, 32'hC0000002, 1'b0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    idle_in();
    settle();
    check_eq("C_wr", {30'd0, wr, wr2}, 32'd3);
    check_eq("C_wdata2", w_data2, 32'hC0000001);
    check_eq("C_wdata", w_data, 32'hC0000002);
    tick();
    settle();
    check_eq("C_cnt", {16'd0, o_push_cnt}, 32'd7);

    // bank_sel stayed 1: a single word lands on bank 2
    drive(1'b1, 2'b01, 32'hD0000001, '0, 1'b0);
    tick();
    idle_in();
    settle();
    check_eq("D_wr", {30'd0, wr, wr2}, 32'd1);
    check_eq("D_data", w_data2, 32'hD0000001);
    tick();

    // hold while filling the queue
    i_hold = 1'b1;
    drive(1'b1, 2'b11, 32'hE0000001, 32'hE0000002, 1'b0);
    tick();
    drive(1'b1, 2'b11, 32'hE0000003, 32'hE0000004, 1'b0);
    settle();
    check_eq("E_ready2", {31'd0, in_ready}, 32'd1);
    check_eq("E_hold_wr", {30'd0, wr, wr2}, 32'd0);
    tick();
    idle_in();
    settle();
    check_eq("E_full_ready", {31'd0, in_ready}, 32'd0);
    check_eq("E_full_wr", {30'd0, wr, wr2}, 32'd0);
    tick();
    i_hold = 1'b0;
    settle();
    check_eq("E12_wr", {30'd0, wr, wr2}, 32'd3);
    check_eq("E12_data", w_data, 32'hE0000001);
    check_eq("E12_data2", w_data2, 32'hE0000002);
    check_eq("E12_ready", {31'd0, in_ready}, 32'd0);
    tick();
    settle();
    check_eq("E34_wr", {30'd0, wr, wr2}, 32'd3);
    check_eq("E34_data", w_data, 32'hE0000003);
    check_eq("E34_data2", w_data2, 32'hE0000004);
    check_eq("E34_ready", {31'd0, in_ready}, 32'd1);
    tick();
    settle();
    check_eq("E_cnt", {16'd0, o_push_cnt}, 32'd12);

    // last pair with push=10 under hold -> DRAIN held, then DONE
    i_hold = 1'b1;
    drive(1'b1, 2'b10, 32'h0BAD0BAD, 32'hF0000001, 1'b1);
    tick();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("F_hold_wr", {30'd0, wr, wr2}, 32'd0);
      check_eq("F_hold_busy", {30'd0, o_busy, o_blk_done}, 32'd2);
      check_eq("F_drain_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    i_hold = 1'b0;
    settle();
    check_eq("F_wr", {30'd0, wr, wr2}, 32'd2);
    check_eq("F_data", w_data, 32'hF0000001);
    check_eq("F_not_done", {31'd0, o_blk_done}, 32'd0);
    tick();
    settle();
    check_eq("F_empty_drain", {30'd0, o_busy, o_blk_done}, 32'd2);
    tick();
    settle();
    check_eq("F_done", {30'd0, o_busy, o_blk_done}, 32'd3);
    tick();
    settle();
    check_eq("F_idle", {30'd0, o_busy, o_blk_done}, 32'd0);
    check_eq("F_cnt", {16'd0, o_push_cnt}, 32'd13);

    // new block; bank_sel is 1 now; reset with 3 words queued
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    settle();
    check_eq("G_cnt_clr", {16'd0, o_push_cnt}, 32'd0);
    i_hold = 1'b1;
    drive(1'b1, 2'b11, 32'h60000001, 32'h60000002, 1'b0);
    tick();
    drive(1'b1, 2'b01, 32'h60000003, '0, 1'b0);
    tick();
    idle_in();
    i_hold = 1'b0;
    settle();
    check_eq("G_wr", {30'd0, wr, wr2}, 32'd3);
    check_eq("G_data2", w_data2, 32'h60000001);
    check_eq("G_data", w_data, 32'h60000002);
    i_reset = 1'b0;
    #1;
    check_eq("G_rst_wr", {30'd0, wr, wr2}, 32'd0);
    check_eq("G_rst_busy", {31'd0, o_busy}, 32'd0);
    tick();
    i_reset = 1'b1;
    tick();
    settle();
    check_eq("G_post_ready", {31'd0, in_ready}, 32'd0);
    check_eq("G_post_wr", {30'd0, wr, wr2}, 32'd0);
    check_eq("G_post_cnt", {16'd0, o_push_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
